// File: rtl/write_ctrl.sv
// write_ctrl: queued single-bank write controller.
// Write requests {row,data} land in a small FIFO; a four-state bank FSM
// pops them one at a time, precharging/activating rows as needed, and
// commits each word into a 16x32 storage array with a one-cycle completion pulse.
module write_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic [31:0] data,
    input  logic        input_valid,
    output logic        full,
    output logic        output_valid,
    output logic [3:0]  done_row,
    input  logic [3:0]  rd_row,
    output logic [31:0] rd_content
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACTIVATE  = 2'd2,
        WRITE     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [35:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [35:0]   fifo_head;
    logic          push;
    logic          pop;

    logic [3:0]    cur_row;
    logic [31:0]   cur_data;
    logic          open_valid;
    logic [3:0]    open_row;
    logic [31:0]   mem [16];

    // Handshake: input_valid has no ready partner. A request is accepted
    // on any posedge where input_valid=1 and full=0; when full=1 it is
    // silently dropped, even if a pop frees a slot on that same edge.
    assign full      = (count == FULL_CNT);
    assign push      = input_valid && !full;
    assign pop       = (state == IDLE) && (count != '0);
    assign fifo_head = fifo_mem[rd_ptr];
    assign rd_content = mem[rd_row];

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {row, data};
    end

    // Bank FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Bank FSM next state: route a popped request by open-row status.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    if (!open_valid)                      state_next = ACTIVATE;
                    else if (open_row == fifo_head[35:32]) state_next = WRITE;
                    else                                  state_next = PRECHARGE;
                end
            end
            PRECHARGE: state_next = ACTIVATE;
            ACTIVATE:  state_next = WRITE;
            WRITE:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Current request latch, open-row tracking and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_row      <= '0;
            cur_data     <= '0;
            open_valid   <= 1'b0;
            open_row     <= '0;
            output_valid <= 1'b0;
            done_row     <= '0;
        end else begin
            output_valid <= (state == WRITE);
            if (pop) begin
                cur_row  <= fifo_head[35:32];
                cur_data <= fifo_head[31:0];
            end
            if (state == PRECHARGE) open_valid <= 1'b0;
            if (state == ACTIVATE) begin
                open_valid <= 1'b1;
                open_row   <= cur_row;
            end
            if (state == WRITE) done_row <= cur_row;
        end
    end

    // Row storage: cleared on reset, written as the FSM leaves WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (state == WRITE) begin
            mem[cur_row] <= cur_data;
        end
    end

endmodule

// File: tb/tb_write_ctrl.sv
// tb_write_ctrl: directed scenarios followed by random traffic, all
// compared cycle by cycle against a transaction-level model of the bank.
module tb_write_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic [31:0] data;
    logic        input_valid;
    logic        full;
    logic        output_valid;
    logic [3:0]  done_row;
    logic [3:0]  rd_row;
    logic [31:0] rd_content;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: queued requests, bank status, storage.
    logic [35:0] exp_q[$];
    logic [31:0] m_mem [16];
    logic        m_open_valid;
    logic [3:0]  m_open_row;
    logic        m_busy;
    int          m_rem;
    logic [35:0] m_cur;
    logic        m_ov;
    logic [3:0]  m_done_row;
    logic [3:0]  obs_q[$];

    write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .data         (data),
        .input_valid  (input_valid),
        .full         (full),
        .output_valid (output_valid),
        .done_row     (done_row),
        .rd_row       (rd_row),
        .rd_content   (rd_content)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge. A popped request finishes 1 edge later on a
    // row hit, 2 on a closed bank, 3 on a row miss; the completion edge
    // never pops. Fullness is judged before any pop on the same edge.
    task automatic model_edge(input logic rst, input logic iv, input logic [3:0] r, input logic [31:0] d);
        bit full_pre;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_open_valid = 1'b0;
            m_open_row   = '0;
            m_busy       = 1'b0;
            m_rem        = 0;
            m_ov         = 1'b0;
            m_done_row   = '0;
        end else begin
            full_pre = (exp_q.size() == DEPTH);
            m_ov = 1'b0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mem[m_cur[35:32]] = m_cur[31:0];
                    m_ov       = 1'b1;
                    m_done_row = m_cur[35:32];
                    m_busy     = 1'b0;
                end
            end else if (exp_q.size() > 0) begin
                m_cur = exp_q.pop_front();
                if (!m_open_valid)                    m_rem = 2;
                else if (m_open_row == m_cur[35:32])  m_rem = 1;
                else                                  m_rem = 3;
                m_open_valid = 1'b1;
                m_open_row   = m_cur[35:32];
                m_busy       = 1'b1;
            end
            if (iv && !full_pre) exp_q.push_back({r, d});
        end
    endtask

    // Driver: apply inputs for one edge, advance model, compare outputs.
    task automatic step(input logic rst, input logic iv, input logic [3:0] r,
                        input logic [31:0] d, input logic [3:0] rr);
        reset       = rst;
        input_valid = iv;
        row         = r;
        data        = d;
        rd_row      = rr;
        @(posedge clk);
        model_edge(rst, iv, r, d);
        #1;
        check("output_valid", 32'(output_valid), 32'(m_ov));
        check("done_row", 32'(done_row), 32'(m_done_row));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("rd_content", rd_content, m_mem[rr]);
        if (output_valid) obs_q.push_back(done_row);
    endtask

    task automatic idle(input int n, input logic [3:0] rr);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 32'd0, rr);
    endtask

    // Push one request into an empty, idle controller and count edges
    // until its completion pulse (bounded).
    task automatic measure(input logic [3:0] r, input logic [31:0] d, input int exp_lat, input string tag);
        int lat;
        logic [3:0] seen_row;
        lat = 0;
        seen_row = '0;
        step(1'b0, 1'b1, r, d, r);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 4'd0, 32'd0, r);
            if (output_valid && lat == 0) begin
                lat = k;
                seen_row = done_row;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_row"}, 32'(seen_row), 32'(r));
        check({tag, "_content"}, rd_content, d);
    endtask

    initial begin
        reset = 1'b1; input_valid = 1'b0; row = '0; data = '0; rd_row = '0;

        // Reset state.
        step(1'b1, 1'b1, 4'd7, 32'h1234, 4'd0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_rd_content", rd_content, 32'd0);
        check("reset_output_valid", 32'(output_valid), 32'd0);
        check("reset_done_row", 32'(done_row), 32'd0);
        idle(2, 4'd3);

        // Closed bank, row hit, row miss.
        measure(4'd2, 32'hDEADBEEF, 3, "closed_r2");
        measure(4'd2, 32'h00000001, 2, "hit_r2");
        measure(4'd9, 32'hA5A5A5A5, 4, "miss_r9");

        // Readback of row 9 across its WRITE edge (hit also proves open_row=9).
        step(1'b0, 1'b1, 4'd9, 32'h0BADF00D, 4'd9);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd9);
        check("wr_cycle_old", rd_content, 32'hA5A5A5A5);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd9);
        check("wr_cycle_new", rd_content, 32'h0BADF00D);
        check("wr_cycle_pulse", 32'(output_valid), 32'd1);
        idle(4, 4'd9);

        // Overflow: six back-to-back pushes, the sixth is dropped.
        obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 4'(i), 32'(i), 4'(i));
            if (i == 4) check("overflow_full", 32'(full), 32'd1);
        end
        idle(20, 4'd5);
        check("overflow_pulses", 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) check("overflow_order", 32'(obs_q[i]), 32'(i));
        check("overflow_r5_untouched", rd_content, 32'd0);

        // Reset during ACTIVATE of row 15 (open row is 4, so this is a miss).
        obs_q.delete();
        step(1'b0, 1'b1, 4'd15, 32'hFFFF0000, 4'd15);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd15);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd15);
        step(1'b1, 1'b1, 4'd15, 32'h77777777, 4'd15);
        check("midflight_full", 32'(full), 32'd0);
        check("midflight_rd15", rd_content, 32'd0);
        idle(6, 4'd15);
        check("midflight_no_pulse", 32'(obs_q.size()), 32'd0);
        measure(4'd3, 32'hCAFE0003, 3, "post_reset_closed");

        // Random traffic, biased toward a few rows to exercise hits.
        for (int k = 0; k < 400; k++) begin
            logic       rst_r;
            logic       iv_r;
            logic [3:0] r_r;
            rst_r = ($urandom_range(0, 63) == 0);
            iv_r  = ($urandom_range(0, 2) != 0);
            r_r   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            step(rst_r, iv_r, r_r, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(20, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
